// File: rtl/uar_top.sv
// UART 8N1 receiver with a configurable bit period and framing-error detection.
// Define UAR_SYNC_EN to add a 2-flop input synchronizer for asynchronous lines.
module uar_top #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  output logic [7:0] dout_byte,
  output logic       dout_rdy,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shreg_reg;
  logic          s_in;

`ifdef UAR_SYNC_EN
  logic sync1_reg, sync2_reg;

  // Both flops reset high so the line reads idle straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= ser_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign s_in = sync2_reg;
`else
  assign s_in = ser_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= WAIT_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= 4'd0;
      shreg_reg   <= 8'h00;
      dout_byte   <= 8'h00;
      dout_rdy    <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      dout_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        WAIT_IDLE: begin
          if (s_in) state_reg <= IDLE;
        end
        IDLE: begin
          if (!s_in) begin
            rx_busy     <= 1'b1;
            bit_cnt_reg <= 4'd0;
            // With one clock per bit there is no mid-bit to wait for.
            if (HALF == 0) begin
              state_reg <= DATA;
              cnt_reg   <= '0;
            end else begin
              state_reg <= START;
              cnt_reg   <= CW'(1);
            end
          end
        end
        START: begin
          if (cnt_reg == HALF_C) begin
            cnt_reg <= '0;
            if (!s_in) begin
              state_reg <= DATA;
            end else begin
              state_reg <= IDLE;
              rx_busy   <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (cnt_reg == LAST_C) begin
            shreg_reg   <= {s_in, shreg_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            cnt_reg     <= '0;
            if (bit_cnt_reg == 4'd7) state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        STOP: begin
          if (cnt_reg == LAST_C) begin
            cnt_reg <= '0;
            rx_busy <= 1'b0;
            if (s_in) begin
              dout_byte <= shreg_reg;
              dout_rdy  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state_reg <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uar_top.sv
// Directed bench for uar_top: one receiver at 1 clock/bit and one at 16 clocks/bit.
module tb_uar_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ser1, ser16;
  logic [7:0] byte1, byte16;
  logic       rdy1, rdy16, ferr1, ferr16, busy1, busy16;

`ifdef UAR_SYNC_EN
  localparam int LAT = 2;
  localparam int RST_LOW_HOLD = 0;
`else
  localparam int LAT = 0;
  localparam int RST_LOW_HOLD = 5;
`endif

  uar_top #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .ser_in(ser1),
    .dout_byte(byte1), .dout_rdy(rdy1), .frame_err(ferr1), .rx_busy(busy1)
  );

  uar_top #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .ser_in(ser16),
    .dout_byte(byte16), .dout_rdy(rdy16), .frame_err(ferr16), .rx_busy(busy16)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle busy history and pulse bookkeeping, sampled mid-cycle.
  bit busy1_h [0:8191];
  bit busy16_h[0:8191];
  int rdy1_n = 0, rdy1_cyc = 0, rdy1_prev_cyc = 0, ferr1_n = 0, ferr1_cyc = 0;
  int rdy16_n = 0, rdy16_cyc = 0, ferr16_n = 0, both_n = 0;
  logic [7:0] rdy1_byte = 8'h00, rdy1_prev_byte = 8'h00, rdy16_byte = 8'h00;

  always @(negedge clk) begin
    if (cyc < 8192) begin
      busy1_h[cyc]  <= busy1;
      busy16_h[cyc] <= busy16;
    end
    if (rdy1) begin
      rdy1_n         <= rdy1_n + 1;
      rdy1_prev_cyc  <= rdy1_cyc;
      rdy1_prev_byte <= rdy1_byte;
      rdy1_cyc       <= cyc;
      rdy1_byte      <= byte1;
    end
    if (ferr1) begin
      ferr1_n   <= ferr1_n + 1;
      ferr1_cyc <= cyc;
    end
    if (rdy16) begin
      rdy16_n    <= rdy16_n + 1;
      rdy16_cyc  <= cyc;
      rdy16_byte <= byte16;
    end
    if (ferr16) ferr16_n <= ferr16_n + 1;
    if ((rdy1 && ferr1) || (rdy16 && ferr16)) both_n <= both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int busy_high(input bit fast, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += fast ? int'(busy1_h[i]) : int'(busy16_h[i]);
    return n;
  endfunction

  task automatic send1(input logic [7:0] b, input logic stop, output int k);
    ser1 = 1'b0;
    k = cyc + 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ser1 = b[i];
      tick();
    end
    ser1 = stop;
    tick();
    $display("tx1  byte=%02h stop=%0b start_edge=%0d", b, stop, k);
  endtask

  task automatic send16(input logic [7:0] b, input logic stop, output int k);
    ser16 = 1'b0;
    k = cyc + 1;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      ser16 = b[i];
      repeat (16) tick();
    end
    ser16 = stop;
    repeat (16) tick();
    $display("tx16 byte=%02h stop=%0b start_edge=%0d", b, stop, k);
  endtask

  initial begin
    int k, k1, k2, r, rdy0, ferr0;

    rst = 1'b1; ser1 = 1'b1; ser16 = 1'b1;
    repeat (3) tick();
    chk("reset_byte1", 32'(byte1), 32'h00);
    chk("reset_rdy1", 32'(rdy1), 32'h0);
    chk("reset_ferr1", 32'(ferr1), 32'h0);
    chk("reset_busy1", 32'(busy1), 32'h0);
    chk("reset_byte16", 32'(byte16), 32'h00);
    rst = 1'b0;

    // Single frame after 3 idle cycles.
    repeat (3) tick();
    send1(8'hA5, 1'b1, k);
    repeat (4) tick();
    chk("single_rdy_count", 32'(rdy1_n), 32'd1);
    chk("single_latency", 32'(rdy1_cyc - k), 32'(9 + LAT));
    chk("single_byte", 32'(rdy1_byte), 32'hA5);
    chk("single_no_ferr", 32'(ferr1_n), 32'd0);

    // Back-to-back frames with no idle gap.
    send1(8'h00, 1'b1, k1);
    send1(8'hFF, 1'b1, k2);
    repeat (4) tick();
    chk("b2b_rdy_count", 32'(rdy1_n), 32'd3);
    chk("b2b_spacing", 32'(rdy1_cyc - rdy1_prev_cyc), 32'd10);
    chk("b2b_first_byte", 32'(rdy1_prev_byte), 32'h00);
    chk("b2b_second_byte", 32'(rdy1_byte), 32'hFF);
    chk("b2b_busy_gap", 32'((k2 + 9 - k1) - busy_high(1'b1, k1 + LAT, k2 + 8 + LAT)), 32'd1);

    // Framing error followed by a held-low line.
    send1(8'h11, 1'b1, k);
    repeat (2) tick();
    chk("ferr_pre_byte", 32'(byte1), 32'h11);
    rdy0 = rdy1_n; ferr0 = ferr1_n;
    send1(8'h3C, 1'b0, k);
    repeat (5) tick();
    chk("ferr_count", 32'(ferr1_n - ferr0), 32'd1);
    chk("ferr_latency", 32'(ferr1_cyc - k), 32'(9 + LAT));
    chk("ferr_no_rdy", 32'(rdy1_n - rdy0), 32'd0);
    chk("ferr_byte_kept", 32'(byte1), 32'h11);
    chk("ferr_no_restart", 32'(busy_high(1'b1, k + 9 + LAT, k + 14)), 32'd0);
    ser1 = 1'b1;
    tick();
    send1(8'h42, 1'b1, k);
    repeat (4) tick();
    chk("ferr_recover_count", 32'(rdy1_n - rdy0), 32'd1);
    chk("ferr_recover_byte", 32'(rdy1_byte), 32'h42);

    // Reset during data bit 4 with the line low.
    rdy0 = rdy1_n; ferr0 = ferr1_n;
    ser1 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      ser1 = 1'b1;
      tick();
    end
    ser1 = 1'b0;
    rst = 1'b1;
    r = cyc + 1;
    tick();
    rst = 1'b0;
    chk("midrst_byte", 32'(byte1), 32'h00);
    chk("midrst_rdy", 32'(rdy1), 32'h0);
    chk("midrst_ferr", 32'(ferr1), 32'h0);
    chk("midrst_busy", 32'(busy1), 32'h0);
    repeat (RST_LOW_HOLD) tick();
    ser1 = 1'b1;
    repeat (15) tick();
    chk("midrst_no_rdy", 32'(rdy1_n - rdy0), 32'd0);
    chk("midrst_no_ferr", 32'(ferr1_n - ferr0), 32'd0);
    chk("midrst_no_start", 32'(busy_high(1'b1, r, cyc)), 32'd0);
    send1(8'h5A, 1'b1, k);
    repeat (4) tick();
    chk("midrst_recover_count", 32'(rdy1_n - rdy0), 32'd1);
    chk("midrst_recover_byte", 32'(byte1), 32'h5A);

    // Oversampled receiver: start-bit glitch, then a real frame.
    ser16 = 1'b0;
    k = cyc + 1;
    tick();
    ser16 = 1'b1;
    repeat (30) tick();
    chk("glitch_busy_cycles", 32'(busy_high(1'b0, k, cyc)), 32'd8);
    chk("glitch_no_rdy", 32'(rdy16_n), 32'd0);
    chk("glitch_no_ferr", 32'(ferr16_n), 32'd0);
    send16(8'h81, 1'b1, k);
    repeat (5) tick();
    chk("os_rdy_count", 32'(rdy16_n), 32'd1);
    chk("os_latency", 32'(rdy16_cyc - k), 32'(8 + 144 + LAT));
    chk("os_byte", 32'(rdy16_byte), 32'h81);
    chk("os_no_ferr", 32'(ferr16_n), 32'd0);

    // Latency check that also covers the synchronizer build.
    rdy0 = rdy1_n;
    send1(8'hC3, 1'b1, k);
    repeat (4) tick();
    chk("c3_rdy_count", 32'(rdy1_n - rdy0), 32'd1);
    chk("c3_latency", 32'(rdy1_cyc - k), 32'(9 + LAT));
    chk("c3_byte", 32'(rdy1_byte), 32'hC3);
    chk("rdy_ferr_exclusive", 32'(both_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
